// File: rtl/alu_packet_parser.sv
// alu_packet_parser: UART byte stream -> framed 32-bit ALU operand words.
// Optional build macro ALU_PARSER_ALIGN_CHECK_EN rejects payloads not a multiple of 4 bytes.
module alu_packet_parser #(
    parameter logic [7:0]  OPC_ECHO = 8'hEC,
    parameter logic [7:0]  OPC_ADD  = 8'hAD,
    parameter logic [7:0]  OPC_MUL  = 8'h88,
    parameter logic [15:0] MAX_LEN  = 16'd1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  op_o,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        word_first_o,
    output logic        word_last_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_OPC,
        S_RSVD,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  opc_q, opc_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] rem_q, rem_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        first_q, first_d;
    logic [7:0]  cur_op_q, cur_op_d;
    // Assembly register; doubles as a one-word skid slot when asm_full_q.
    logic [31:0] asm_q, asm_d;
    logic        asm_full_q, asm_full_d;
    logic        asm_first_q, asm_first_d;
    logic        asm_last_q, asm_last_d;
    logic [7:0]  asm_op_q, asm_op_d;
    // Output register.
    logic [7:0]  op_q, op_d;
    logic [31:0] word_q, word_d;
    logic        wvalid_q, wvalid_d;
    logic        wfirst_q, wfirst_d;
    logic        wlast_q, wlast_d;
    logic        err_q, err_d;

    logic        out_free;
    logic        rx_ready;
    logic        byte_ok;
    logic [15:0] len_w;
    logic [15:0] len_lim;
    logic [15:0] drop_n;
    logic        op_ok;
    logic        hdr_bad;
    logic        complete;
    logic        pending_next;
    logic [31:0] word_new;

    // Handshake, header check and byte-lane helper terms.
    always_comb begin
        out_free     = !wvalid_q || word_ready_i;
        rx_ready     = !(asm_full_q && !out_free);
        byte_ok      = rx_valid_i && rx_ready;
        pending_next = asm_full_q || (wvalid_q && !word_ready_i);
        len_w        = {rx_data_i, len_lo_q};
        len_lim      = (len_w > MAX_LEN) ? MAX_LEN : len_w;
        drop_n       = len_lim - 16'd4;
        op_ok        = (opc_q == OPC_ECHO) || (opc_q == OPC_ADD) ||
                       (opc_q == OPC_MUL);
`ifdef ALU_PARSER_ALIGN_CHECK_EN
        hdr_bad      = !op_ok || (len_w < 16'd4) || (len_w > MAX_LEN) ||
                       (len_w[1:0] != 2'b00);
`else
        hdr_bad      = !op_ok || (len_w < 16'd4) || (len_w > MAX_LEN);
`endif
        word_new     = (cnt_q == 2'd0) ? 32'd0 : asm_q;
        word_new[{cnt_q, 3'b000} +: 8] = rx_data_i;
        complete     = byte_ok && (state_q == S_DATA) &&
                       ((cnt_q == 2'd3) || (rem_q == 16'd1));
    end

    // Next-state: header parse, payload assembly and output register loading.
    always_comb begin
        state_d     = state_q;
        opc_d       = opc_q;
        len_lo_d    = len_lo_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        cur_op_d    = cur_op_q;
        asm_d       = asm_q;
        asm_full_d  = asm_full_q;
        asm_first_d = asm_first_q;
        asm_last_d  = asm_last_q;
        asm_op_d    = asm_op_q;
        op_d        = op_q;
        word_d      = word_q;
        wvalid_d    = wvalid_q;
        wfirst_d    = wfirst_q;
        wlast_d     = wlast_q;
        err_d       = 1'b0;

        unique case (state_q)
            S_OPC: if (byte_ok) begin
                opc_d   = rx_data_i;
                state_d = S_RSVD;
            end
            S_RSVD: if (byte_ok) state_d = S_LEN_LO;
            S_LEN_LO: if (byte_ok) begin
                len_lo_d = rx_data_i;
                state_d  = S_LEN_HI;
            end
            S_LEN_HI: if (byte_ok) begin
                // Keep op_o tied to any word still waiting for the ALU.
                if (!pending_next) op_d = opc_q;
                if (hdr_bad) begin
                    err_d = 1'b1;
                    if ((len_w < 16'd4) || (drop_n == 16'd0)) begin
                        state_d = S_OPC;
                    end else begin
                        rem_d   = drop_n;
                        state_d = S_DROP;
                    end
                end else if (len_w == 16'd4) begin
                    state_d = S_OPC;
                end else begin
                    rem_d    = len_w - 16'd4;
                    cnt_d    = 2'd0;
                    first_d  = 1'b1;
                    cur_op_d = opc_q;
                    state_d  = S_DATA;
                end
            end
            S_DATA: if (byte_ok) begin
                asm_d = word_new;
                cnt_d = cnt_q + 2'd1;
                rem_d = rem_q - 16'd1;
                if (complete) begin
                    cnt_d   = 2'd0;
                    first_d = 1'b0;
                end
                if (rem_q == 16'd1) state_d = S_OPC;
            end
            S_DROP: if (byte_ok) begin
                rem_d = rem_q - 16'd1;
                if (rem_q == 16'd1) state_d = S_OPC;
            end
            default: state_d = S_OPC;
        endcase

        if (asm_full_q && out_free) begin
            word_d     = asm_q;
            wvalid_d   = 1'b1;
            wfirst_d   = asm_first_q;
            wlast_d    = asm_last_q;
            op_d       = asm_op_q;
            asm_full_d = 1'b0;
            if (complete) begin
                asm_full_d  = 1'b1;
                asm_first_d = first_q;
                asm_last_d  = (rem_q == 16'd1);
                asm_op_d    = cur_op_q;
            end
        end else if (complete && out_free) begin
            word_d   = word_new;
            wvalid_d = 1'b1;
            wfirst_d = first_q;
            wlast_d  = (rem_q == 16'd1);
            op_d     = cur_op_q;
        end else if (complete) begin
            asm_full_d  = 1'b1;
            asm_first_d = first_q;
            asm_last_d  = (rem_q == 16'd1);
            asm_op_d    = cur_op_q;
        end else if (wvalid_q && word_ready_i) begin
            wvalid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_OPC;
            opc_q       <= 8'd0;
            len_lo_q    <= 8'd0;
            rem_q       <= 16'd0;
            cnt_q       <= 2'd0;
            first_q     <= 1'b0;
            cur_op_q    <= 8'd0;
            asm_q       <= 32'd0;
            asm_full_q  <= 1'b0;
            asm_first_q <= 1'b0;
            asm_last_q  <= 1'b0;
            asm_op_q    <= 8'd0;
            op_q        <= 8'd0;
            word_q      <= 32'd0;
            wvalid_q    <= 1'b0;
            wfirst_q    <= 1'b0;
            wlast_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            opc_q       <= opc_d;
            len_lo_q    <= len_lo_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            cur_op_q    <= cur_op_d;
            asm_q       <= asm_d;
            asm_full_q  <= asm_full_d;
            asm_first_q <= asm_first_d;
            asm_last_q  <= asm_last_d;
            asm_op_q    <= asm_op_d;
            op_q        <= op_d;
            word_q      <= word_d;
            wvalid_q    <= wvalid_d;
            wfirst_q    <= wfirst_d;
            wlast_q     <= wlast_d;
            err_q       <= err_d;
        end
    end

    assign rx_ready_o   = rx_ready;
    assign op_o         = op_q;
    assign word_o       = word_q;
    assign word_valid_o = wvalid_q;
    assign word_first_o = wfirst_q;
    assign word_last_o  = wlast_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_alu_packet_parser.sv
// tb_alu_packet_parser: directed vector table plus hand sequences for
// backpressure, oversize drop and mid-packet reset of alu_packet_parser.
module tb_alu_packet_parser;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  rx_data_i = 8'd0;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  op_o;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        word_ready_i = 1'b1;
    logic        word_first_o;
    logic        word_last_o;
    logic        err_o;

    alu_packet_parser dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .rx_ready_o   (rx_ready_o),
        .op_o         (op_o),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .word_first_o (word_first_o),
        .word_last_o  (word_last_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    logic [42:0] wq[$];

    // Held-word stability tracking.
    logic        hold_vld = 1'b0;
    logic [42:0] hold_w;

    // Monitor: negedge view of what the next posedge will transfer.
    always @(negedge clk_i) begin
        if (err_o) err_cnt++;
        if (hold_vld) begin
            total++;
            if (!word_valid_o ||
                {op_o, word_first_o, word_last_o, word_o} !== hold_w) begin
                bad++;
                $display("FAIL hold_stable got v=%0b %h want v=1 %h",
                         word_valid_o,
                         {op_o, word_first_o, word_last_o, word_o}, hold_w);
            end
        end
        hold_vld = word_valid_o && !word_ready_i;
        hold_w   = {op_o, word_first_o, word_last_o, word_o};
        if (word_valid_o && word_ready_i)
            wq.push_back({op_o, word_first_o, word_last_o, word_o});
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit go;
        go = 1'b0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        for (int k = 0; k < 200 && !go; k++) begin
            @(negedge clk_i);
            go = rx_ready_o;
            @(posedge clk_i);
            #1;
        end
        if (!go) begin
            total++;
            bad++;
            $display("FAIL send_timeout got ready=0 want ready=1 byte %h", b);
        end
    endtask

    task automatic idle(input int n);
        rx_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    typedef struct {
        logic [127:0] b;
        int           n;
        int           err;
        int           nw;
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic [7:0]   op;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{128'hEC000800_42694269_00000000_00000000, 8,
                    0, 1, 32'h69426942, 32'h0, 8'hEC};
`ifdef ALU_PARSER_ALIGN_CHECK_EN
        vecs[1] = '{128'hAD000700_01020300_00000000_00000000, 7,
                    1, 0, 32'h0, 32'h0, 8'hAD};
`else
        vecs[1] = '{128'hAD000700_01020300_00000000_00000000, 7,
                    0, 1, 32'h00030201, 32'h0, 8'hAD};
`endif
        vecs[2] = '{128'h55000800_DEADBEEF_00000000_00000000, 8,
                    1, 0, 32'h0, 32'h0, 8'h00};
        vecs[3] = '{128'hAD000400_88000C00_01020304_05060708, 16,
                    0, 2, 32'h04030201, 32'h08070605, 8'h88};
`ifdef ALU_PARSER_ALIGN_CHECK_EN
        vecs[4] = '{128'hEC000900_11223344_55000000_00000000, 9,
                    1, 0, 32'h0, 32'h0, 8'hEC};
        vecs[6] = '{128'h88000500_07000000_00000000_00000000, 5,
                    1, 0, 32'h0, 32'h0, 8'h88};
`else
        vecs[4] = '{128'hEC000900_11223344_55000000_00000000, 9,
                    0, 2, 32'h44332211, 32'h00000055, 8'hEC};
        vecs[6] = '{128'h88000500_07000000_00000000_00000000, 5,
                    0, 1, 32'h00000007, 32'h0, 8'h88};
`endif
        vecs[5] = '{128'hAD000300_EC000800_01020304_00000000, 12,
                    1, 1, 32'h04030201, 32'h0, 8'hEC};

        // Reset state.
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", 64'(rx_ready_o), 64'd1);
        chk("rst_valid", 64'(word_valid_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_outs", {23'd0, op_o, word_o, word_first_o, word_last_o},
            64'd0);
        rst_i = 1'b0;
        idle(2);

        // Table-driven packets.
        for (int v = 0; v < 7; v++) begin
            wq.delete();
            err_cnt = 0;
            word_ready_i = 1'b1;
            for (int i = 0; i < vecs[v].n; i++)
                send_byte(vecs[v].b[127 - 8 * i -: 8]);
            idle(5);
            chk($sformatf("v%0d_err", v), 64'(err_cnt), 64'(vecs[v].err));
            chk($sformatf("v%0d_nw", v), 64'(wq.size()), 64'(vecs[v].nw));
            for (int j = 0; j < vecs[v].nw && j < wq.size(); j++)
                chk($sformatf("v%0d_w%0d", v, j), 64'(wq[j]),
                    64'({vecs[v].op, j == 0, j == vecs[v].nw - 1,
                         (j == 0) ? vecs[v].w0 : vecs[v].w1}));
        end

        // Backpressure: ALU stalls 20 cycles over a 2-word MUL packet.
        wq.delete();
        err_cnt = 0;
        word_ready_i = 1'b0;
        send_byte(8'h88); send_byte(8'h00);
        send_byte(8'h0C); send_byte(8'h00);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        rx_valid_i = 1'b0;
        @(negedge clk_i);
        chk("bp_ready_low", 64'(rx_ready_o), 64'd0);
        chk("bp_held", {21'd0, word_valid_o, op_o, word_first_o,
                        word_last_o, word_o},
            {21'd0, 1'b1, 8'h88, 1'b1, 1'b0, 32'h04030201});
        repeat (20) @(posedge clk_i);
        #1;
        word_ready_i = 1'b1;
        idle(5);
        chk("bp_nw", 64'(wq.size()), 64'd2);
        if (wq.size() == 2) begin
            chk("bp_w0", 64'(wq[0]), 64'({8'h88, 1'b1, 1'b0, 32'h04030201}));
            chk("bp_w1", 64'(wq[1]), 64'({8'h88, 1'b0, 1'b1, 32'h08070605}));
        end
        chk("bp_err", 64'(err_cnt), 64'd0);

        // Oversized len 1025: drop exactly 1020 bytes, then parse next packet.
        wq.delete();
        err_cnt = 0;
        send_byte(8'hEC); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h04);
        for (int i = 0; i < 1020; i++) send_byte(8'hEC);
        send_byte(8'hEC); send_byte(8'h00);
        send_byte(8'h08); send_byte(8'h00);
        send_byte(8'hA1); send_byte(8'hB2);
        send_byte(8'hC3); send_byte(8'hD4);
        idle(5);
        chk("big_err", 64'(err_cnt), 64'd1);
        chk("big_nw", 64'(wq.size()), 64'd1);
        if (wq.size() == 1)
            chk("big_w0", 64'(wq[0]), 64'({8'hEC, 1'b1, 1'b1, 32'hD4C3B2A1}));

        // Reset mid-DATA after 2 payload bytes, then a fresh packet.
        wq.delete();
        err_cnt = 0;
        send_byte(8'hEC); send_byte(8'h00);
        send_byte(8'h08); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        rx_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("mid_rst", {29'd0, word_valid_o, rx_ready_o, op_o},
            {29'd0, 1'b0, 1'b1, 8'h00});
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(1);
        send_byte(8'hEC); send_byte(8'h00);
        send_byte(8'h08); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h03); send_byte(8'h04);
        idle(5);
        chk("post_rst_nw", 64'(wq.size()), 64'd1);
        if (wq.size() == 1)
            chk("post_rst_w", 64'(wq[0]),
                64'({8'hEC, 1'b1, 1'b1, 32'h04030201}));
        chk("post_rst_err", 64'(err_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
